huffman_code_ctrl: RTL and testbench

Sequencer for the Huffman code-construction phase of the 6-symbol gray-level coder. It captures the six symbol counts when the counter stage pulses CNT_valid. It then runs five bottom-up merge rounds over a single shared scan/compare datapath. It publishes a right-aligned code word and a length mask per symbol, with a one-cycle code_valid pulse.

---
 rtl/huffman_code_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_huffman_code_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/huffman_code_ctrl.sv
// Huffman code-construction sequencer for a 6-symbol coder: captures counts, runs five
// scan/merge rounds over one shared compare datapath and publishes per-symbol codes and masks.
module huffman_code_ctrl #(
    parameter int CW = 8,
    parameter int SW = 11,
    parameter int HW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          CNT_valid,
    input  logic [CW-1:0] CNT1,
    input  logic [CW-1:0] CNT2,
    input  logic [CW-1:0] CNT3,
    input  logic [CW-1:0] CNT4,
    input  logic [CW-1:0] CNT5,
    input  logic [CW-1:0] CNT6,
    output logic          busy,
    output logic          code_valid,
    output logic [HW-1:0] HC1,
    output logic [HW-1:0] HC2,
    output logic [HW-1:0] HC3,
    output logic [HW-1:0] HC4,
    output logic [HW-1:0] HC5,
    output logic [HW-1:0] HC6,
    output logic [HW-1:0] M1,
    output logic [HW-1:0] M2,
    output logic [HW-1:0] M3,
    output logic [HW-1:0] M4,
    output logic [HW-1:0] M5,
    output logic [HW-1:0] M6
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        MERGE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt [1:6];

    logic [SW-1:0] sum_q [1:6];
    logic [SW-1:0] sum_d [1:6];
    logic [6:1]    act_q, act_d;
    logic [2:0]    g_q   [1:6];
    logic [2:0]    g_d   [1:6];
    logic [2:0]    len_q [1:6];
    logic [2:0]    len_d [1:6];
    logic [HW-1:0] hc_q  [1:6];
    logic [HW-1:0] hc_d  [1:6];
    logic [HW-1:0] m_q   [1:6];
    logic [HW-1:0] m_d   [1:6];

    logic [2:0]    round_q, round_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    min1_q, min1_d;
    logic [2:0]    min2_q, min2_d;
    logic [SW-1:0] min1s_q, min1s_d;
    logic [SW-1:0] min2s_q, min2s_d;
    logic          busy_q, busy_d;
    logic          cv_q, cv_d;

    logic [SW-1:0] cand;
    logic [2:0]    mrg_id;
    logic [2:0]    oth_id;

    assign cnt[1] = CNT1;
    assign cnt[2] = CNT2;
    assign cnt[3] = CNT3;
    assign cnt[4] = CNT4;
    assign cnt[5] = CNT5;
    assign cnt[6] = CNT6;

    // The merged group keeps the lower id so surviving ids stay packed toward 1.
    assign mrg_id = (min1_q < min2_q) ? min1_q : min2_q;
    assign oth_id = (min1_q < min2_q) ? min2_q : min1_q;
    assign cand   = sum_q[idx_q];

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        act_d   = act_q;
        g_d     = g_q;
        len_d   = len_q;
        hc_d    = hc_q;
        m_d     = m_q;
        round_d = round_q;
        idx_d   = idx_q;
        min1_d  = min1_q;
        min2_d  = min2_q;
        min1s_d = min1s_q;
        min2s_d = min2s_q;
        busy_d  = busy_q;
        cv_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (CNT_valid) begin
                    for (int k = 1; k <= 6; k++) begin
                        sum_d[k] = SW'(cnt[k]);
                        g_d[k]   = 3'(k);
                        len_d[k] = 3'd0;
                        hc_d[k]  = '0;
                        m_d[k]   = '0;
                    end
                    act_d   = '1;
                    round_d = 3'd1;
                    idx_d   = 3'd1;
                    min1_d  = 3'd0;
                    min2_d  = 3'd0;
                    min1s_d = '1;
                    min2s_d = '1;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                // Non-strict compares: on equal sums the later (higher) id wins min1.
                if (act_q[idx_q]) begin
                    if (cand <= min1s_q) begin
                        min2_d  = min1_q;
                        min2s_d = min1s_q;
                        min1_d  = idx_q;
                        min1s_d = cand;
                    end else if (cand <= min2s_q) begin
                        min2_d  = idx_q;
                        min2s_d = cand;
                    end
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd6) begin
                    state_d = MERGE;
                end
            end

            MERGE: begin
                for (int s = 1; s <= 6; s++) begin
                    if (g_q[s] == min1_q) begin
                        hc_d[s][len_q[s]] = 1'b1;
                        m_d[s][len_q[s]]  = 1'b1;
                        len_d[s]          = len_q[s] + 3'd1;
                        g_d[s]            = mrg_id;
                    end else if (g_q[s] == min2_q) begin
                        hc_d[s][len_q[s]] = 1'b0;
                        m_d[s][len_q[s]]  = 1'b1;
                        len_d[s]          = len_q[s] + 3'd1;
                        g_d[s]            = mrg_id;
                    end
                end
                sum_d[mrg_id] = min1s_q + min2s_q;
                act_d[oth_id] = 1'b0;
                min1s_d       = '1;
                min2s_d       = '1;
                idx_d         = 3'd1;
                if (round_q == 3'd5) begin
                    cv_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    round_d = round_q + 3'd1;
                    state_d = SCAN;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int k = 1; k <= 6; k++) begin
                sum_q[k] <= '0;
                g_q[k]   <= '0;
                len_q[k] <= '0;
                hc_q[k]  <= '0;
                m_q[k]   <= '0;
            end
            act_q   <= '0;
            round_q <= '0;
            idx_q   <= '0;
            min1_q  <= '0;
            min2_q  <= '0;
            min1s_q <= '0;
            min2s_q <= '0;
            busy_q  <= 1'b0;
            cv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            g_q     <= g_d;
            len_q   <= len_d;
            hc_q    <= hc_d;
            m_q     <= m_d;
            act_q   <= act_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            min1s_q <= min1s_d;
            min2s_q <= min2s_d;
            busy_q  <= busy_d;
            cv_q    <= cv_d;
        end
    end

    assign busy       = busy_q;
    assign code_valid = cv_q;
    assign HC1 = hc_q[1];
    assign HC2 = hc_q[2];
    assign HC3 = hc_q[3];
    assign HC4 = hc_q[4];
    assign HC5 = hc_q[5];
    assign HC6 = hc_q[6];
    assign M1  = m_q[1];
    assign M2  = m_q[2];
    assign M3  = m_q[3];
    assign M4  = m_q[4];
    assign M5  = m_q[5];
    assign M6  = m_q[6];

endmodule

// File: tb/tb_huffman_code_ctrl.sv
// Scoreboard bench for huffman_code_ctrl: directed builds push expected codes, a monitor
// pops and compares on every code_valid pulse.
module tb_huffman_code_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       CNT_valid = 1'b0;
    logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
    logic       busy, code_valid;
    logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0] M1, M2, M3, M4, M5, M6;

    always #5 clk = ~clk;

    huffman_code_ctrl #(.CW(8), .SW(11), .HW(8)) dut (
        .clk(clk), .reset(reset), .CNT_valid(CNT_valid),
        .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3), .CNT4(CNT4), .CNT5(CNT5), .CNT6(CNT6),
        .busy(busy), .code_valid(code_valid),
        .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
        .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6)
    );

    // Packed per-symbol vectors: symbol 1 occupies bits [7:0].
    typedef struct packed {
        logic [47:0] hc;
        logic [47:0] m;
        logic [31:0] due;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic        cv_prev = 1'b0;

    localparam logic [47:0] T1_CNT = {8'd20, 8'd15, 8'd5, 8'd30, 8'd20, 8'd10};
    localparam logic [47:0] T1_HC  = {8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h00};
    localparam logic [47:0] T1_M   = {8'h03, 8'h07, 8'h0F, 8'h03, 8'h03, 8'h0F};
    localparam logic [47:0] T2_CNT = 48'h0;
    localparam logic [47:0] T2_HC  = {8'h1F, 8'h1E, 8'h0E, 8'h06, 8'h02, 8'h00};
    localparam logic [47:0] T2_M   = {8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
    localparam logic [47:0] T6_CNT = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100};
    localparam logic [47:0] ALT_CNT = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [47:0] act_hc();
        return {HC6, HC5, HC4, HC3, HC2, HC1};
    endfunction

    function automatic logic [47:0] act_m();
        return {M6, M5, M4, M3, M2, M1};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (cv_prev) chk("code_valid_one_cycle", {47'd0, code_valid}, 48'd0);
        cv_prev = code_valid;
        if (code_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_code_valid", 48'd1, 48'd0);
            end else begin
                e = exp_q.pop_front();
                chk("latency_cycle", {16'd0, cyc}, {16'd0, e.due});
                chk("busy_at_done", {47'd0, busy}, 48'd0);
                for (int i = 0; i < 6; i++) begin
                    chk($sformatf("HC%0d", i + 1), {40'd0, act_hc()[8*i +: 8]}, {40'd0, e.hc[8*i +: 8]});
                    chk($sformatf("M%0d", i + 1), {40'd0, act_m()[8*i +: 8]}, {40'd0, e.m[8*i +: 8]});
                end
            end
        end
    end

    task automatic drive_cnt(input logic [47:0] c);
        {CNT6, CNT5, CNT4, CNT3, CNT2, CNT1} = c;
    endtask

    // Pulse CNT_valid for the coming edge E0 and queue the result due 35 edges later.
    task automatic start_now(input logic [47:0] c, input logic [47:0] hc, input logic [47:0] m);
        exp_t e;
        drive_cnt(c);
        CNT_valid = 1'b1;
        @(posedge clk);
        #1;
        CNT_valid = 1'b0;
        e.hc  = hc;
        e.m   = m;
        e.due = cyc + 35;
        exp_q.push_back(e);
        chk("busy_after_E0", {47'd0, busy}, 48'd1);
    endtask

    task automatic start(input logic [47:0] c, input logic [47:0] hc, input logic [47:0] m);
        @(negedge clk);
        start_now(c, hc, m);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("build_timeout", 48'd1, 48'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        drive_cnt(48'd0);
        #12;
        chk("reset_busy", {47'd0, busy}, 48'd0);
        chk("reset_code_valid", {47'd0, code_valid}, 48'd0);
        chk("reset_HC", act_hc(), 48'd0);
        chk("reset_M", act_m(), 48'd0);
        @(negedge clk);
        reset = 1'b0;

        // Mixed counts
        start(T1_CNT, T1_HC, T1_M);
        wait_done();

        // All-zero counts exercise the tie-break ordering
        start(T2_CNT, T2_HC, T2_M);
        wait_done();

        // Busy still high just before E35, then no further pulse
        start(T1_CNT, T1_HC, T1_M);
        repeat (34) @(posedge clk);
        #1;
        chk("busy_at_E34", {47'd0, busy}, 48'd1);
        wait_done();
        repeat (40) @(posedge clk);

        // Re-pulse while busy is ignored; back-to-back accept on the code_valid cycle
        start(T1_CNT, T1_HC, T1_M);
        repeat (9) @(posedge clk);
        @(negedge clk);
        drive_cnt(ALT_CNT);
        CNT_valid = 1'b1;
        @(posedge clk);
        #1;
        CNT_valid = 1'b0;
        chk("busy_after_ignored_pulse", {47'd0, busy}, 48'd1);
        begin
            int n = 0;
            @(negedge clk);
            while (code_valid !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("code_valid_seen_for_b2b", {47'd0, code_valid}, 48'd1);
        end
        start_now(T2_CNT, T2_HC, T2_M);
        wait_done();

        // Asynchronous reset in the middle of round-3 scanning
        start(T1_CNT, T1_HC, T1_M);
        repeat (17) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        void'(exp_q.pop_back());
        chk("async_rst_busy", {47'd0, busy}, 48'd0);
        chk("async_rst_code_valid", {47'd0, code_valid}, 48'd0);
        chk("async_rst_HC", act_hc(), 48'd0);
        chk("async_rst_M", act_m(), 48'd0);
        @(negedge clk);
        reset = 1'b0;
        start(T1_CNT, T1_HC, T1_M);
        wait_done();

        // One dominant symbol: same tree shape as all-zero counts
        start(T6_CNT, T2_HC, T2_M);
        wait_done();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
